// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: wait-stated data memory controller for the microprocessor.
// Serves level RD/WR requests with word/halfword/byte access on big-endian byte lanes.
// It also flags malformed requests.
// Optional feature macro: DATAMEM_BOUNDS_CHECK_EN. When it is defined, any address
// above the array depth is rejected. When it is undefined, the upper address bits
// alias the array instead.
//
// Handshake: a request is accepted at any rising edge where the FSM is IDLE and
// RD or WR is high. At that edge the address, store data, size and direction are
// captured. Busy stays high until the access completes, and all other inputs are
// ignored during that time. Completion is a single-cycle ACK, with Error qualifying
// it. The requester drops RD/WR in the ACK cycle. A level still high in the
// following IDLE cycle is taken as a new request.
`timescale 1ns/1ps

module data_memory_ctrl #(
  parameter int DATAWIDTH_BUS = 32,
  parameter int ADDRWIDTH     = 10,
  parameter int WAIT_STATES   = 2
) (
  input  logic                     DataMemCtrl_CLOCK_50,
  input  logic                     DataMemCtrl_Reset_InLow,
  input  logic                     DataMemCtrl_Selector_RD,
  input  logic                     DataMemCtrl_Selector_WR,
  input  logic [1:0]               DataMemCtrl_Size_In,
  input  logic [DATAWIDTH_BUS-1:0] DataMemCtrl_Address_In,
  input  logic [DATAWIDTH_BUS-1:0] DataMemCtrl_Data_In,
  output logic [DATAWIDTH_BUS-1:0] DataMemCtrl_Data_Out,
  output logic                     DataMemCtrl_Busy,
  output logic                     DataMemCtrl_ACK,
  output logic                     DataMemCtrl_Error,
  output logic [1:0]               dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q;
  logic                   wr_q;
  logic                   err_q;
  logic [1:0]             size_q;
  logic [1:0]             off_q;
  logic [ADDRWIDTH-1:0]   idx_q;
  logic [31:0]            wdata_q;
  logic                   req;
  logic                   req_err;
  logic [3:0]             be;
  logic [31:0]            wlane;
  logic [31:0]            rword;
  logic [31:0]            rdata;
  logic [31:0]            mem [0:(1<<ADDRWIDTH)-1];

  assign req       = DataMemCtrl_Selector_RD | DataMemCtrl_Selector_WR;
  assign dbg_state = state_q;

`ifndef DATAMEM_BOUNDS_CHECK_EN
  // Upper address bits intentionally alias the array in this build
  logic unused_addr_hi;
  assign unused_addr_hi = ^DataMemCtrl_Address_In[DATAWIDTH_BUS-1:ADDRWIDTH+2];
`endif

  // Classify the live request as rejected (checked only when it is captured)
  always_comb begin
    req_err = 1'b0;
    if (DataMemCtrl_Selector_RD && DataMemCtrl_Selector_WR) req_err = 1'b1;
    if (DataMemCtrl_Size_In == 2'b11) req_err = 1'b1;
    if (DataMemCtrl_Size_In == 2'b01 && DataMemCtrl_Address_In[0]) req_err = 1'b1;
    if (DataMemCtrl_Size_In == 2'b00 && DataMemCtrl_Address_In[1:0] != 2'b00) req_err = 1'b1;
`ifdef DATAMEM_BOUNDS_CHECK_EN
    if (|DataMemCtrl_Address_In[DATAWIDTH_BUS-1:ADDRWIDTH+2]) req_err = 1'b1;
`endif
  end

  // State register; reset aborts any access in flight
  always_ff @(posedge DataMemCtrl_CLOCK_50) begin
    if (!DataMemCtrl_Reset_InLow) state_q <= ST_IDLE;
    else                          state_q <= state_d;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d           = state_q;
    DataMemCtrl_Busy  = (state_q != ST_IDLE);
    DataMemCtrl_ACK   = 1'b0;
    DataMemCtrl_Error = 1'b0;
    case (state_q)
      ST_IDLE:   if (req) state_d = (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;
      ST_WAIT:   if (cnt_q == 4'd1) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_DONE;
      ST_DONE: begin
        state_d           = ST_IDLE;
        DataMemCtrl_ACK   = 1'b1;
        DataMemCtrl_Error = err_q;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // Capture the request in IDLE and run the wait-state down-counter
  always_ff @(posedge DataMemCtrl_CLOCK_50) begin
    if (!DataMemCtrl_Reset_InLow) begin
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      off_q   <= 2'b00;
      idx_q   <= '0;
      wdata_q <= 32'h0;
    end else if (state_q == ST_IDLE && req) begin
      cnt_q   <= 4'(WAIT_STATES);
      wr_q    <= DataMemCtrl_Selector_WR;
      err_q   <= req_err;
      size_q  <= DataMemCtrl_Size_In;
      off_q   <= DataMemCtrl_Address_In[1:0];
      idx_q   <= DataMemCtrl_Address_In[ADDRWIDTH+1:2];
      wdata_q <= DataMemCtrl_Data_In[31:0];
    end else if (state_q == ST_WAIT) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Lane decode: byte-enable bit 3 is offset 0 (bits 31:24), bit 0 is offset 3
  always_comb begin
    be    = 4'b1111;
    wlane = wdata_q;
    rword = mem[idx_q];
    rdata = rword;
    case (size_q)
      2'b01: begin
        be    = off_q[1] ? 4'b0011 : 4'b1100;
        wlane = {2{wdata_q[15:0]}};
        rdata = off_q[1] ? {16'h0, rword[15:0]} : {16'h0, rword[31:16]};
      end
      2'b10: begin
        wlane = {4{wdata_q[7:0]}};
        case (off_q)
          2'd0:    begin be = 4'b1000; rdata = {24'h0, rword[31:24]}; end
          2'd1:    begin be = 4'b0100; rdata = {24'h0, rword[23:16]}; end
          2'd2:    begin be = 4'b0010; rdata = {24'h0, rword[15:8]};  end
          default: begin be = 4'b0001; rdata = {24'h0, rword[7:0]};   end
        endcase
      end
      default: begin
        be    = 4'b1111;
        rdata = rword;
      end
    endcase
  end

  // Array write at the closing edge of ACCESS; reset or rejection suppresses it
  always_ff @(posedge DataMemCtrl_CLOCK_50) begin
    if (DataMemCtrl_Reset_InLow && state_q == ST_ACCESS && wr_q && !err_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx_q][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  // Load register: reads capture lane data, rejected requests force zero
  always_ff @(posedge DataMemCtrl_CLOCK_50) begin
    if (!DataMemCtrl_Reset_InLow) begin
      DataMemCtrl_Data_Out <= '0;
    end else if (state_q == ST_ACCESS) begin
      if (err_q)      DataMemCtrl_Data_Out <= '0;
      else if (!wr_q) DataMemCtrl_Data_Out <= DATAWIDTH_BUS'(rdata);
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: directed bench for data_memory_ctrl with WAIT_STATES=2 and ADDRWIDTH=10.
// It runs with or without DATAMEM_BOUNDS_CHECK_EN.
`timescale 1ns/1ps

module tb_data_memory_ctrl;

  localparam int LAT = 4;  // WAIT_STATES + 2
`ifdef DATAMEM_BOUNDS_CHECK_EN
  localparam logic BOUNDS = 1'b1;
`else
  localparam logic BOUNDS = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        rd;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        busy;
  logic        ack;
  logic        err;
  logic [1:0]  dbg_state;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  logic [31:0] exp_q[$];

  data_memory_ctrl #(
    .DATAWIDTH_BUS(32),
    .ADDRWIDTH(10),
    .WAIT_STATES(2)
  ) dut (
    .DataMemCtrl_CLOCK_50(clk),
    .DataMemCtrl_Reset_InLow(rst_n),
    .DataMemCtrl_Selector_RD(rd),
    .DataMemCtrl_Selector_WR(wr),
    .DataMemCtrl_Size_In(size),
    .DataMemCtrl_Address_In(addr),
    .DataMemCtrl_Data_In(din),
    .DataMemCtrl_Data_Out(dout),
    .DataMemCtrl_Busy(busy),
    .DataMemCtrl_ACK(ack),
    .DataMemCtrl_Error(err),
    .dbg_state(dbg_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One request: drive at a negedge, drop RD/WR after the sampling edge, then
  // scramble the other inputs (they must be ignored while busy) and watch for ACK.
  task automatic do_access(input string tag, input logic r, input logic w,
                           input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] d, input logic exp_err,
                           input logic chk_data, input logic [31:0] exp_data);
    int   n;
    int   busy_n;
    logic got_ack;
    @(negedge clk);
    rd = r; wr = w; size = sz; addr = a; din = d;
    if (chk_data) exp_q.push_back(exp_data);
    @(posedge clk);
    #1;
    rd = 1'b0; wr = 1'b0;
    size = 2'($urandom_range(0, 3));
    addr = $urandom;
    din  = $urandom;
    n = 0; busy_n = 0; got_ack = 1'b0;
    while (!got_ack && n < 20) begin
      @(negedge clk);
      n++;
      if (busy) busy_n++;
      if (ack) begin
        got_ack = 1'b1;
        check_eq({tag, "_err"}, 32'(err), 32'(exp_err));
        if (chk_data && exp_q.size() > 0) check_eq({tag, "_data"}, dout, exp_q.pop_front());
      end
    end
    check_eq({tag, "_ack_latency"}, 32'(n), 32'(LAT));
    check_eq({tag, "_busy_cycles"}, 32'(busy_n), 32'(LAT));
    @(negedge clk);
    check_eq({tag, "_ack_drop"}, 32'(ack), 32'd0);
    check_eq({tag, "_busy_drop"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; rd = 1'b0; wr = 1'b0; size = 2'b00; addr = 32'h0; din = 32'h0;

    // reset state
    repeat (3) @(negedge clk);
    check_eq("rst_busy",  32'(busy), 32'd0);
    check_eq("rst_ack",   32'(ack),  32'd0);
    check_eq("rst_err",   32'(err),  32'd0);
    check_eq("rst_dout",  dout,      32'h0);
    check_eq("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;

    // known contents for later checks
    do_access("init_w0",  1'b0, 1'b1, 2'b00, 32'h0,  32'h0, 1'b0, 1'b0, 32'h0);
    do_access("init_w40", 1'b0, 1'b1, 2'b00, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0);

    // 1: word write / read
    do_access("t1_wr", 1'b0, 1'b1, 2'b00, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
    do_access("t1_rd", 1'b1, 1'b0, 2'b00, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);

    // 2: byte store merge and narrow loads
    do_access("t2_wr",   1'b0, 1'b1, 2'b00, 32'h10, 32'h11223344, 1'b0, 1'b0, 32'h0);
    do_access("t2_wrb",  1'b0, 1'b1, 2'b10, 32'h13, 32'h000000AB, 1'b0, 1'b0, 32'h0);
    do_access("t2_rdw",  1'b1, 1'b0, 2'b00, 32'h10, 32'h0, 1'b0, 1'b1, 32'h112233AB);
    do_access("t2_rdb2", 1'b1, 1'b0, 2'b10, 32'h12, 32'h0, 1'b0, 1'b1, 32'h00000033);
    do_access("t2_rdh0", 1'b1, 1'b0, 2'b01, 32'h10, 32'h0, 1'b0, 1'b1, 32'h00001122);
    do_access("t2_rdb3", 1'b1, 1'b0, 2'b10, 32'h13, 32'h0, 1'b0, 1'b1, 32'h000000AB);
    do_access("t2_rdh2", 1'b1, 1'b0, 2'b01, 32'h12, 32'h0, 1'b0, 1'b1, 32'h000033AB);
    do_access("t2_rdb0", 1'b1, 1'b0, 2'b10, 32'h10, 32'h0, 1'b0, 1'b1, 32'h00000011);

    // 3: rejected requests
    do_access("t3_wr20", 1'b0, 1'b1, 2'b00, 32'h20, 32'hA5A55A5A, 1'b0, 1'b0, 32'h0);
    do_access("t3_rd20", 1'b1, 1'b0, 2'b00, 32'h20, 32'h0, 1'b0, 1'b1, 32'hA5A55A5A);
    do_access("t3_rdh11",  1'b1, 1'b0, 2'b01, 32'h11, 32'h0, 1'b1, 1'b1, 32'h0);
    do_access("t3_size11", 1'b1, 1'b0, 2'b11, 32'h20, 32'h0, 1'b1, 1'b1, 32'h0);
    do_access("t3_rdwr",   1'b1, 1'b1, 2'b00, 32'h20, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0);
    do_access("t3_wrh11",  1'b0, 1'b1, 2'b01, 32'h11, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0);
    do_access("t3_wrw12",  1'b0, 1'b1, 2'b00, 32'h12, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0);
    do_access("t3_chk10",  1'b1, 1'b0, 2'b00, 32'h10, 32'h0, 1'b0, 1'b1, 32'h112233AB);
    do_access("t3_chk20",  1'b1, 1'b0, 2'b00, 32'h20, 32'h0, 1'b0, 1'b1, 32'hA5A55A5A);

    // 4: out-of-range address
    do_access("t4_wr1000", 1'b0, 1'b1, 2'b00, 32'h1000, 32'hCAFEF00D, BOUNDS, BOUNDS, 32'h0);
    do_access("t4_rd0",    1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1,
              BOUNDS ? 32'h0 : 32'hCAFEF00D);
    do_access("t4_rd1000", 1'b1, 1'b0, 2'b00, 32'h1000, 32'h0, BOUNDS, 1'b1,
              BOUNDS ? 32'h0 : 32'hCAFEF00D);

    // 5: reset during the second WAIT cycle aborts the write
    @(negedge clk);
    wr = 1'b1; size = 2'b00; addr = 32'h40; din = 32'h55555555;
    @(posedge clk);
    #1;
    wr = 1'b0; addr = $urandom; din = $urandom;
    @(negedge clk);
    check_eq("t5_busy_w1", 32'(busy), 32'd1);
    @(negedge clk);
    check_eq("t5_busy_w2", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("t5_busy_after_rst", 32'(busy), 32'd0);
    check_eq("t5_ack_after_rst",  32'(ack),  32'd0);
    check_eq("t5_dout_after_rst", dout,      32'h0);
    check_eq("t5_state_after_rst", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_eq("t5_no_ack", 32'(ack), 32'd0);
    end
    do_access("t5_rd40", 1'b1, 1'b0, 2'b00, 32'h40, 32'h0, 1'b0, 1'b1, 32'h0);

    // 6: RD held through ACK gives back-to-back accesses every 5 cycles
    @(negedge clk);
    rd = 1'b1; wr = 1'b0; size = 2'b00; addr = 32'h10; din = 32'h0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      check_eq("t6_busy", 32'(busy), (cyc % 5 != 0) ? 32'd1 : 32'd0);
      check_eq("t6_ack",  32'(ack),  (cyc % 5 == 4) ? 32'd1 : 32'd0);
      if (cyc % 5 == 4) begin
        check_eq("t6_data", dout, 32'h112233AB);
        check_eq("t6_err",  32'(err), 32'd0);
      end
      if (cyc == 14) rd = 1'b0;
    end
    for (int cyc = 15; cyc <= 17; cyc++) begin
      @(negedge clk);
      check_eq("t6_idle_busy", 32'(busy), 32'd0);
      check_eq("t6_idle_ack",  32'(ack),  32'd0);
    end

    check_eq("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
